// File: rtl/blit_pkg.sv
// Shared types and helpers for the blitter write path.
package blit_pkg;

  localparam int unsigned BLIT_ADDR_W = 26;

  typedef enum logic {
    BPP8  = 1'b0,
    BPP16 = 1'b1
  } blit_bpp_t;

  // Byte-enable mask for one pixel within a word of 'bytes' lanes (bytes <= 8).
  // 16 bpp pixels are forced onto an even lane so they never straddle a word.
  function automatic logic [7:0] lane_mask(blit_bpp_t bpp, logic [2:0] lane, int unsigned bytes);
    logic [7:0] m;
    logic [7:0] lim;
    lim = 8'hff >> (8 - bytes);
    if (bpp == BPP16) m = 8'b0000_0011 << {lane[2:1], 1'b0};
    else              m = 8'b0000_0001 << lane;
    return m & lim;
  endfunction

endpackage

// File: rtl/blit_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and sticky overflow on dropped pushes.
module blit_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             empty, full, do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DepthC);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

  // Storage is not reset, so mask the head while empty.
  assign rdata    = empty ? '0 : mem[rptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/blit_write_combiner.sv
// Combines 8/16 bpp pixel writes into byte-enabled words and queues them for the SDRAM arbiter.
module blit_write_combiner
  import blit_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = BLIT_ADDR_W,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned FULL_MARGIN = 2,
  localparam int unsigned BYTES      = DATA_W / 8,
  localparam int unsigned LW         = $clog2(BYTES),
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [15:0]       in_data,
  input  logic              in_bpp16,
  input  logic              in_idle,
  output logic              out_req,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [BYTES-1:0]  out_byte_enable,
  input  logic              out_ack,
  output logic              fifo_full,
  output logic [CW-1:0]     fifo_count,
  output logic              busy,
  output logic              overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } wentry_t;

  localparam int unsigned EW = ADDR_W + DATA_W + BYTES;

  wentry_t   cr_q, cr_d, pix, merged, push_entry, head;
  logic      cr_valid_q, cr_valid_d, push;
  logic [2:0] lane;
  blit_bpp_t bpp;

  always_comb begin
    lane          = '0;
    lane[LW-1:0]  = in_addr[LW-1:0];
    bpp           = in_bpp16 ? BPP16 : BPP8;
    pix.addr      = {in_addr[ADDR_W-1:LW], {LW{1'b0}}};
    pix.be        = BYTES'(lane_mask(bpp, lane, BYTES));
    merged.addr   = cr_q.addr;
    merged.be     = cr_q.be | pix.be;
    for (int b = 0; b < int'(BYTES); b++) begin
      // Odd lanes of a 16 bpp pixel carry its high byte.
      pix.data[8*b +: 8]    = !pix.be[b] ? 8'h00 :
                              ((in_bpp16 && (b % 2 == 1)) ? in_data[15:8] : in_data[7:0]);
      merged.data[8*b +: 8] = pix.be[b] ? pix.data[8*b +: 8] : cr_q.data[8*b +: 8];
    end
  end

  always_comb begin
    cr_d       = cr_q;
    cr_valid_d = cr_valid_q;
    push       = 1'b0;
    push_entry = cr_q;
    if (in_write) begin
      if (cr_valid_q && (cr_q.addr == pix.addr)) begin
        if (&merged.be) begin
          push       = 1'b1;
          push_entry = merged;
          cr_valid_d = 1'b0;
        end else begin
          cr_d = merged;
        end
      end else begin
        push       = cr_valid_q;
        cr_valid_d = 1'b1;
        cr_d       = pix;
      end
    end else if (in_idle && cr_valid_q) begin
      push       = 1'b1;
      cr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cr_valid_q <= 1'b0;
      cr_q       <= '0;
    end else begin
      cr_valid_q <= cr_valid_d;
      cr_q       <= cr_d;
    end
  end

  blit_sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wdata   (push_entry),
    .pop     (out_ack),
    .rdata   (head),
    .count   (fifo_count),
    .overflow(overflow)
  );

  assign out_req         = (fifo_count != '0);
  assign out_addr        = head.addr;
  assign out_data        = head.data;
  assign out_byte_enable = head.be;
  assign fifo_full       = (fifo_count >= CW'(DEPTH - FULL_MARGIN));
  assign busy            = cr_valid_q || out_req;

endmodule

// File: tb/tb_blit_write_combiner.sv
// Scoreboard bench for blit_write_combiner at DATA_W=32, DEPTH=8, FULL_MARGIN=2.
module tb_blit_write_combiner;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 26;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BYTES-1:0]  be;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              in_write = 1'b0;
  logic [ADDR_W-1:0] in_addr = '0;
  logic [15:0]       in_data = '0;
  logic              in_bpp16 = 1'b0;
  logic              in_idle = 1'b0;
  logic              out_req;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [BYTES-1:0]  out_byte_enable;
  logic              out_ack = 1'b0;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              busy;
  logic              overflow;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  blit_write_combiner #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .FULL_MARGIN(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_write       (in_write),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_bpp16       (in_bpp16),
    .in_idle        (in_idle),
    .out_req        (out_req),
    .out_addr       (out_addr),
    .out_data       (out_data),
    .out_byte_enable(out_byte_enable),
    .out_ack        (out_ack),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every accepted head word against the scoreboard, away from the rising edge.
  always @(negedge clock) begin
    if (reset && out_req && out_ack) begin
      check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out_addr", 64'(out_addr), 64'(e.addr));
        check_eq("out_data", 64'(out_data), 64'(e.data));
        check_eq("out_be",   64'(out_byte_enable), 64'(e.be));
      end
    end
  end

  task automatic px(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic b16);
    in_write = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_bpp16 = b16;
    @(posedge clock);
    #1;
    in_write = 1'b0;
  endtask

  task automatic idle_cyc();
    in_idle = 1'b1;
    @(posedge clock);
    #1;
    in_idle = 1'b0;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [BYTES-1:0] be);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((busy || sb.size() != 0) && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [15:0]       lo, hi;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_req",   64'(out_req), 64'd0);
    check_eq("rst_full",  64'(fifo_full), 64'd0);
    check_eq("rst_busy",  64'(busy), 64'd0);
    check_eq("rst_ovf",   64'(overflow), 64'd0);
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    check_eq("rst_data",  64'(out_data), 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Four 8 bpp bytes fill one word, pushed early on the fourth write.
    out_ack = 1'b1;
    px(26'h100, 16'h0011, 1'b0);
    px(26'h101, 16'h0022, 1'b0);
    px(26'h102, 16'h0033, 1'b0);
    check_eq("t1_no_early_req", 64'(out_req), 64'd0);
    push_exp(26'h100, 32'h44332211, 4'b1111);
    px(26'h103, 16'h0044, 1'b0);
    check_eq("t1_req_latency", 64'(out_req), 64'd1);
    wait_drain("t1");

    // Different-word write pushes the old word; idle flushes the partial one.
    push_exp(26'h200, 32'h000000AA, 4'b0001);
    push_exp(26'h204, 32'h000000BB, 4'b0001);
    px(26'h200, 16'h00AA, 1'b0);
    px(26'h204, 16'h00BB, 1'b0);
    idle_cyc();
    wait_drain("t2");

    push_exp(26'h300, 32'hBEEF1234, 4'b1111);
    px(26'h302, 16'hBEEF, 1'b1);
    px(26'h300, 16'h1234, 1'b1);
    wait_drain("t3");

    push_exp(26'h300, 32'h0000CAFE, 4'b0011);
    px(26'h301, 16'hCAFE, 1'b1);
    idle_cyc();
    wait_drain("t4");

    push_exp(26'h100, 32'h00000022, 4'b0001);
    px(26'h100, 16'h0011, 1'b0);
    px(26'h100, 16'h0022, 1'b0);
    idle_cyc();
    wait_drain("t5");

    // Fill the FIFO with no acks.
    out_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a  = 26'h1000 + 26'(4 * k);
      lo = 16'(16'h0101 * k);
      hi = 16'hA000 | 16'(k);
      push_exp(a, {hi, lo}, 4'b1111);
      px(a, lo, 1'b1);
      px(a + 26'd2, hi, 1'b1);
      if (k == 4) check_eq("full_below_margin", 64'(fifo_full), 64'd0);
      if (k == 5) begin
        check_eq("full_at_6", 64'(fifo_full), 64'd1);
        check_eq("count_6", 64'(fifo_count), 64'd6);
      end
    end
    check_eq("count_8", 64'(fifo_count), 64'd8);
    check_eq("no_ovf_at_8", 64'(overflow), 64'd0);

    // Push at full with a simultaneous ack is accepted.
    push_exp(26'h1020, 32'hA0080808, 4'b1111);
    px(26'h1020, 16'h0808, 1'b1);
    out_ack = 1'b1;
    px(26'h1022, 16'hA008, 1'b1);
    out_ack = 1'b0;
    check_eq("simul_count", 64'(fifo_count), 64'd8);
    check_eq("simul_ovf", 64'(overflow), 64'd0);

    // Push at full without ack is dropped.
    px(26'h1024, 16'h0909, 1'b1);
    px(26'h1026, 16'hA009, 1'b1);
    check_eq("drop_count", 64'(fifo_count), 64'd8);
    check_eq("drop_ovf", 64'(overflow), 64'd1);
    out_ack = 1'b1;
    wait_drain("t6");
    check_eq("ovf_sticky", 64'(overflow), 64'd1);
    check_eq("t6_count", 64'(fifo_count), 64'd0);

    // Asynchronous reset with a partial word in the combining register.
    out_ack = 1'b0;
    px(26'h500, 16'h0077, 1'b0);
    check_eq("t7_busy_pre", 64'(busy), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t7_rst_req", 64'(out_req), 64'd0);
    check_eq("t7_rst_busy", 64'(busy), 64'd0);
    check_eq("t7_rst_count", 64'(fifo_count), 64'd0);
    check_eq("t7_rst_ovf", 64'(overflow), 64'd0);
    @(posedge clock);
    #1;
    reset   = 1'b1;
    out_ack = 1'b1;
    in_idle = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      #1;
      check_eq("t7_no_stale_req", 64'(out_req), 64'd0);
    end
    in_idle = 1'b0;
    check_eq("t7_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/blit_write_combiner.md
Name: blit_write_combiner

Overview:
Parametrised successor to the blitter's final two pipeline stages, pixel merge followed by the write FIFO. Accepts single-pixel writes at 8 or 16 bpp and combines them into DATA_W-wide little-endian words with byte enables. Buffers the words in a DEPTH-entry FIFO and drains them to the SDRAM arbiter write port over a req/ack handshake. Adds 16 bpp mode, early push on complete words, an almost-full margin for upstream skid, sticky overflow and a busy flag.

Parameters:
DATA_W, 32, output word width in bits; 32 or 64 only.
ADDR_W, 26, byte address width.
DEPTH, 8, FIFO entries; power of two, minimum 4.
FULL_MARGIN, 2, fifo_full asserts when count >= DEPTH-FULL_MARGIN; this covers upstream pipeline depth.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_write  in  1  pixel write strobe
in_addr  in  ADDR_W  pixel byte address; bit0 ignored in 16 bpp mode
in_data  in  16  pixel data; [7:0] used in 8 bpp mode
in_bpp16  in  1  0 = 8 bpp pixel, 1 = 16 bpp pixel; sampled per write
in_idle  in  1  upstream pipeline empty; requests a flush
out_req  out  1  FIFO head valid
out_addr  out  ADDR_W  head word address; low log2(DATA_W/8) bits are zero
out_data  out  DATA_W  head data
out_byte_enable  out  DATA_W/8  head byte enables
out_ack  in  1  arbiter accepted the head this cycle
fifo_full  out  1  almost-full; upstream must stall
fifo_count  out  log2(DEPTH)+1  occupied entries
busy  out  1  combining register valid or FIFO non-empty
overflow  out  1  sticky flag: a push was dropped

Behaviour:
- Reset (reset=0, asynchronous): FIFO pointers, count, combining register and overflow cleared. out_req=0, fifo_full=0, busy=0, overflow=0, out_* data=0. Reset asserted mid-operation discards all pending data with no partial write.
- Lane mapping: lane = in_addr[log2(DATA_W/8)-1:0].
  - 8 bpp: enables one byte.
  - 16 bpp: lane bit0 is forced to 0; enables lanes L and L+1, low byte in L.
  - A pixel never straddles words.
- Combining register (CR) holds valid, word address, data and byte enables.
- On in_write, with W = word address of in_addr:
  - CR empty: load the pixel into CR.
  - CR valid, same W: merge; new bytes overwrite old (last write wins); enables are OR'd.
  - CR valid, different W: push CR to the FIFO, then load the pixel into CR.
- Early push: if the merged enables are all ones, push the merged word the same cycle and leave CR empty. At most one push occurs per cycle in every case.
- Flush: in_idle=1 and in_write=0 and CR valid pushes CR and clears it. in_idle is ignored while in_write=1.
- Latency: the cycle after a push, out_req=1, given the FIFO was empty. A partial word waits until a different-word write or an idle flush.
- FIFO behaviour:
  - Show-ahead: out_* present the head combinationally from storage.
  - Pop on out_req && out_ack; out_ack while empty is ignored.
  - Simultaneous push and pop: count unchanged, and this is legal at count=DEPTH.
  - Push at count=DEPTH without a pop: the entry is dropped and overflow is set until reset.
- Pointers wrap modulo DEPTH. fifo_count equals DEPTH exactly when full.
- fifo_full and busy are combinational from registered state.
- Order: words leave in push order. There is no reordering or collapsing of FIFO entries.

Decomposition:
- Shared package blit_pkg holds:
  - BLIT_ADDR_W.
  - Enum blit_bpp_t {BPP8, BPP16}.
  - Parametrised struct blit_wentry_t {addr, data, be}, or equivalent typedef macros.
  - Helper function lane_mask(bpp, lane, BYTES).
- One sub-module, blit_sync_fifo(WIDTH, DEPTH): show-ahead storage with count, push/pop, and simultaneous-operation rules as above. The combining logic stays in blit_write_combiner.

Test Plan:
- DATA_W=32: 8 bpp writes on consecutive cycles to 0x100..0x103 with data 11,22,33,44 -> one entry with addr 0x100, data 0x44332211, be 1111; out_req rises the cycle after the 4th write.
- 8 bpp writes 0x200=AA and 0x204=BB, then in_idle=1 -> two entries in order: (0x200, 0x000000AA, 0001) then (0x204, 0x000000BB, 0001).
- 16 bpp writes 0x302=BEEF and 0x300=1234 -> one entry (0x300, 0xBEEF1234, 1111).
- 16 bpp write to odd address 0x301=CAFE, then idle -> entry (0x300, 0x0000CAFE, 0011).
- 8 bpp writes 0x100=11 then 0x100=22, then idle -> entry (0x100, 0x00000022, 0001).
- DEPTH=8, FULL_MARGIN=2, out_ack=0:
  - Push 6 full words -> fifo_full=1 at count 6.
  - Push 3 more -> count 8, overflow=1.
  - Raise out_ack -> the first 8 words drain in order, and busy falls after the last ack.
- At count 8, push with simultaneous ack -> count stays 8, overflow unchanged.
- Assert reset while CR holds a partial word -> out_req=0, busy=0, fifo_count=0 immediately; after release no stale write appears.
